// File: rtl/vga_frame_write_arbiter.sv
// Frame-buffer write-port owner: round-robin merge of two pixel producers plus a
// frame-synchronised whole-buffer clear, with out-of-range address dropping.
module vga_frame_write_arbiter #(
  parameter int unsigned MEM_SIZE = 19200,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              err_clr,
  output logic              err_oob,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  typedef enum logic [1:0] {RUN, ARM, CLEAR} state_t;

  // One extra bit so MEM_SIZE == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   SIZE_EXT  = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic [DATA_W-1:0]   color, color_d;
  logic                rr_last, rr_last_d;
  logic                wr_en_d, clear_done_d, clear_busy_d, err_oob_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  logic                grant_any, grant_sel, accept_en, xfer, xfer_oob;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;

  // Round-robin grant and combinational handshake.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~rr_last;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
    accept_en  = !rst && (state == RUN) && !clear_start;
    req0_ready = accept_en && grant_any && !grant_sel;
    req1_ready = accept_en && grant_any && grant_sel;
    xfer       = req0_ready | req1_ready;
    xfer_addr  = grant_sel ? req1_addr : req0_addr;
    xfer_data  = grant_sel ? req1_data : req0_data;
    xfer_oob   = {1'b0, xfer_addr} >= SIZE_EXT;
  end

  // Next-state and next-output logic; cnt mirrors the clear address on the bus.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    color_d      = color;
    rr_last_d    = rr_last;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    clear_done_d = 1'b0;
    err_oob_d    = err_clr ? 1'b0 : err_oob;

    case (state)
      RUN: begin
        if (clear_start) begin
          state_d = ARM;
          color_d = clear_color;
        end else if (xfer) begin
          rr_last_d = grant_sel;
          if (xfer_oob) begin
            err_oob_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = xfer_addr;
            wr_data_d = xfer_data;
          end
        end
      end
      ARM: begin
        if (frame_done) begin
          state_d      = CLEAR;
          cnt_d        = '0;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = color;
          clear_done_d = (LAST_ADDR == '0);
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d        = cnt + ADDR_W'(1);
          wr_en_d      = 1'b1;
          wr_addr_d    = cnt_d;
          wr_data_d    = color;
          clear_done_d = (cnt_d == LAST_ADDR);
        end
      end
      default: state_d = RUN;
    endcase

    clear_busy_d = (state_d != RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      color      <= '0;
      rr_last    <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      color      <= color_d;
      rr_last    <= rr_last_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      clear_busy <= clear_busy_d;
      clear_done <= clear_done_d;
      err_oob    <= err_oob_d;
    end
  end

endmodule
